// File: rtl/alu_rs_scheduler_pkg.sv
// Shared widths, opcode encodings and the station entry layout for the ALU reservation station.
package alu_rs_scheduler_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int DATA_WIDTH          = 32;
  localparam int ROB_TAG_WIDTH       = 4;
  localparam int INSIDE_OPCODE_WIDTH = 6;
  localparam int RS_SIZE_DEF         = 8;

  typedef enum logic [INSIDE_OPCODE_WIDTH-1:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_AND  = 6'd3,
    OP_OR   = 6'd4,
    OP_XOR  = 6'd5,
    OP_ADDI = 6'd6,
    OP_BEQ  = 6'd16,
    OP_BNE  = 6'd17,
    OP_JAL  = 6'd24,
    OP_JALR = 6'd25
  } opcode_e;

  typedef struct packed {
    logic [INSIDE_OPCODE_WIDTH-1:0] op;
    logic [DATA_WIDTH-1:0]          vj;
    logic [ROB_TAG_WIDTH-1:0]       qj;
    logic                           rj;
    logic [DATA_WIDTH-1:0]          vk;
    logic [ROB_TAG_WIDTH-1:0]       qk;
    logic                           rk;
    logic [DATA_WIDTH-1:0]          imm;
    logic [DATA_WIDTH-1:0]          pc;
    logic [ROB_TAG_WIDTH-1:0]       reorder;
  } rs_entry_t;

endpackage

// File: rtl/alu_rs_scheduler_rs_prio_enc.sv
// Lowest-set-bit priority encoder; purely combinational, no backpressure.
module rs_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    // Scan downward so the lowest set bit is the final assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = i[W-1:0];
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: dispatch-to-issue min 2 edges, one issue per cycle, lowest index first.
// Backpressure: out_dec_full when no entry is free; rdy low freezes everything.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE  = RS_SIZE_DEF,
  parameter int RS_IDX_W = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           in_rob_flush,
  input  logic                           in_dec_valid,
  input  logic [INSIDE_OPCODE_WIDTH-1:0] in_dec_op,
  input  logic [DATA_WIDTH-1:0]          in_dec_rs1_value,
  input  logic [ROB_TAG_WIDTH-1:0]       in_dec_rs1_tag,
  input  logic                           in_dec_rs1_ready,
  input  logic [DATA_WIDTH-1:0]          in_dec_rs2_value,
  input  logic [ROB_TAG_WIDTH-1:0]       in_dec_rs2_tag,
  input  logic                           in_dec_rs2_ready,
  input  logic [DATA_WIDTH-1:0]          in_dec_imm,
  input  logic [DATA_WIDTH-1:0]          in_dec_pc,
  input  logic [ROB_TAG_WIDTH-1:0]       in_dec_reorder,
  output logic                           out_dec_full,
  input  logic                           in_alu_cdb_valid,
  input  logic [ROB_TAG_WIDTH-1:0]       in_alu_cdb_reorder,
  input  logic [DATA_WIDTH-1:0]          in_alu_cdb_value,
  input  logic                           in_lsb_cdb_valid,
  input  logic [ROB_TAG_WIDTH-1:0]       in_lsb_cdb_reorder,
  input  logic [DATA_WIDTH-1:0]          in_lsb_cdb_value,
  output logic                           out_alu_valid,
  output logic [INSIDE_OPCODE_WIDTH-1:0] out_alu_op,
  output logic [DATA_WIDTH-1:0]          out_alu_rs1,
  output logic [DATA_WIDTH-1:0]          out_alu_rs2,
  output logic [DATA_WIDTH-1:0]          out_alu_imm,
  output logic [DATA_WIDTH-1:0]          out_alu_pc,
  output logic [ROB_TAG_WIDTH-1:0]       out_alu_reorder
);

  rs_entry_t           r_ent [RS_SIZE];
  logic [RS_SIZE-1:0]  r_busy;

  logic [RS_SIZE-1:0]  w_free_vec;
  logic [RS_SIZE-1:0]  w_ready_vec;
  logic [RS_IDX_W-1:0] w_free_idx;
  logic [RS_IDX_W-1:0] w_iss_idx;
  logic                w_free_any;
  logic                w_iss_any;
  rs_entry_t           w_new;

  always_comb begin
    w_free_vec  = '0;
    w_ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_free_vec[i]  = !r_busy[i];
      w_ready_vec[i] = r_busy[i] && r_ent[i].rj && r_ent[i].rk;
    end
  end

  rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_sel (
    .i_vec (w_free_vec),
    .o_idx (w_free_idx),
    .o_any (w_free_any)
  );

  rs_prio_enc #(.N(RS_SIZE), .W(RS_IDX_W)) u_iss_sel (
    .i_vec (w_ready_vec),
    .o_idx (w_iss_idx),
    .o_any (w_iss_any)
  );

  assign out_dec_full = !w_free_any;

  // Incoming operands may be satisfied by a broadcast in the dispatch cycle itself.
  always_comb begin
    w_new         = '0;
    w_new.op      = in_dec_op;
    w_new.vj      = in_dec_rs1_value;
    w_new.qj      = in_dec_rs1_tag;
    w_new.rj      = in_dec_rs1_ready;
    w_new.vk      = in_dec_rs2_value;
    w_new.qk      = in_dec_rs2_tag;
    w_new.rk      = in_dec_rs2_ready;
    w_new.imm     = in_dec_imm;
    w_new.pc      = in_dec_pc;
    w_new.reorder = in_dec_reorder;
    if (!in_dec_rs1_ready) begin
      if (in_alu_cdb_valid && in_alu_cdb_reorder == in_dec_rs1_tag) begin
        w_new.vj = in_alu_cdb_value;
        w_new.rj = TRUE;
      end else if (in_lsb_cdb_valid && in_lsb_cdb_reorder == in_dec_rs1_tag) begin
        w_new.vj = in_lsb_cdb_value;
        w_new.rj = TRUE;
      end
    end
    if (!in_dec_rs2_ready) begin
      if (in_alu_cdb_valid && in_alu_cdb_reorder == in_dec_rs2_tag) begin
        w_new.vk = in_alu_cdb_value;
        w_new.rk = TRUE;
      end else if (in_lsb_cdb_valid && in_lsb_cdb_reorder == in_dec_rs2_tag) begin
        w_new.vk = in_lsb_cdb_value;
        w_new.rk = TRUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy          <= '0;
      out_alu_valid   <= FALSE;
      out_alu_op      <= '0;
      out_alu_rs1     <= '0;
      out_alu_rs2     <= '0;
      out_alu_imm     <= '0;
      out_alu_pc      <= '0;
      out_alu_reorder <= '0;
    end else if (rdy) begin
      if (in_rob_flush) begin
        r_busy        <= '0;
        out_alu_valid <= FALSE;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && !r_ent[i].rj) begin
            if (in_alu_cdb_valid && in_alu_cdb_reorder == r_ent[i].qj) begin
              r_ent[i].vj <= in_alu_cdb_value;
              r_ent[i].rj <= TRUE;
            end else if (in_lsb_cdb_valid && in_lsb_cdb_reorder == r_ent[i].qj) begin
              r_ent[i].vj <= in_lsb_cdb_value;
              r_ent[i].rj <= TRUE;
            end
          end
          if (r_busy[i] && !r_ent[i].rk) begin
            if (in_alu_cdb_valid && in_alu_cdb_reorder == r_ent[i].qk) begin
              r_ent[i].vk <= in_alu_cdb_value;
              r_ent[i].rk <= TRUE;
            end else if (in_lsb_cdb_valid && in_lsb_cdb_reorder == r_ent[i].qk) begin
              r_ent[i].vk <= in_lsb_cdb_value;
              r_ent[i].rk <= TRUE;
            end
          end
        end

        if (w_iss_any) begin
          out_alu_valid     <= TRUE;
          out_alu_op        <= r_ent[w_iss_idx].op;
          out_alu_rs1       <= r_ent[w_iss_idx].vj;
          out_alu_rs2       <= r_ent[w_iss_idx].vk;
          out_alu_imm       <= r_ent[w_iss_idx].imm;
          out_alu_pc        <= r_ent[w_iss_idx].pc;
          out_alu_reorder   <= r_ent[w_iss_idx].reorder;
          r_busy[w_iss_idx] <= FALSE;
        end else begin
          out_alu_valid <= FALSE;
        end

        // The free slot is never the issuing slot, so a freed entry waits a cycle before reuse.
        if (in_dec_valid && w_free_any) begin
          r_ent[w_free_idx]  <= w_new;
          r_busy[w_free_idx] <= TRUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: hand-computed expectations checked with immediate assertions.
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        in_rob_flush = 1'b0;
  logic        in_dec_valid = 1'b0;
  logic [5:0]  in_dec_op = '0;
  logic [31:0] in_dec_rs1_value = '0;
  logic [3:0]  in_dec_rs1_tag = '0;
  logic        in_dec_rs1_ready = 1'b0;
  logic [31:0] in_dec_rs2_value = '0;
  logic [3:0]  in_dec_rs2_tag = '0;
  logic        in_dec_rs2_ready = 1'b0;
  logic [31:0] in_dec_imm = '0;
  logic [31:0] in_dec_pc = '0;
  logic [3:0]  in_dec_reorder = '0;
  logic        out_dec_full;
  logic        in_alu_cdb_valid = 1'b0;
  logic [3:0]  in_alu_cdb_reorder = '0;
  logic [31:0] in_alu_cdb_value = '0;
  logic        in_lsb_cdb_valid = 1'b0;
  logic [3:0]  in_lsb_cdb_reorder = '0;
  logic [31:0] in_lsb_cdb_value = '0;
  logic        out_alu_valid;
  logic [5:0]  out_alu_op;
  logic [31:0] out_alu_rs1;
  logic [31:0] out_alu_rs2;
  logic [31:0] out_alu_imm;
  logic [31:0] out_alu_pc;
  logic [3:0]  out_alu_reorder;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_rs_scheduler #(.RS_SIZE(8), .RS_IDX_W(3)) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .in_rob_flush       (in_rob_flush),
    .in_dec_valid       (in_dec_valid),
    .in_dec_op          (in_dec_op),
    .in_dec_rs1_value   (in_dec_rs1_value),
    .in_dec_rs1_tag     (in_dec_rs1_tag),
    .in_dec_rs1_ready   (in_dec_rs1_ready),
    .in_dec_rs2_value   (in_dec_rs2_value),
    .in_dec_rs2_tag     (in_dec_rs2_tag),
    .in_dec_rs2_ready   (in_dec_rs2_ready),
    .in_dec_imm         (in_dec_imm),
    .in_dec_pc          (in_dec_pc),
    .in_dec_reorder     (in_dec_reorder),
    .out_dec_full       (out_dec_full),
    .in_alu_cdb_valid   (in_alu_cdb_valid),
    .in_alu_cdb_reorder (in_alu_cdb_reorder),
    .in_alu_cdb_value   (in_alu_cdb_value),
    .in_lsb_cdb_valid   (in_lsb_cdb_valid),
    .in_lsb_cdb_reorder (in_lsb_cdb_reorder),
    .in_lsb_cdb_value   (in_lsb_cdb_value),
    .out_alu_valid      (out_alu_valid),
    .out_alu_op         (out_alu_op),
    .out_alu_rs1        (out_alu_rs1),
    .out_alu_rs2        (out_alu_rs2),
    .out_alu_imm        (out_alu_imm),
    .out_alu_pc         (out_alu_pc),
    .out_alu_reorder    (out_alu_reorder)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic [5:0] op,
                      input logic [31:0] v1, input logic [3:0] q1, input logic r1,
                      input logic [31:0] v2, input logic [3:0] q2, input logic r2,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
    in_dec_valid     = 1'b1;
    in_dec_op        = op;
    in_dec_rs1_value = v1;
    in_dec_rs1_tag   = q1;
    in_dec_rs1_ready = r1;
    in_dec_rs2_value = v2;
    in_dec_rs2_tag   = q2;
    in_dec_rs2_ready = r2;
    in_dec_imm       = imm;
    in_dec_pc        = pc;
    in_dec_reorder   = rob;
  endtask

  task automatic idle();
    in_dec_valid     = 1'b0;
    in_alu_cdb_valid = 1'b0;
    in_lsb_cdb_valid = 1'b0;
  endtask

  task automatic alu_cdb(input logic [3:0] tag, input logic [31:0] val);
    in_alu_cdb_valid   = 1'b1;
    in_alu_cdb_reorder = tag;
    in_alu_cdb_value   = val;
  endtask

  task automatic lsb_cdb(input logic [3:0] tag, input logic [31:0] val);
    in_lsb_cdb_valid   = 1'b1;
    in_lsb_cdb_reorder = tag;
    in_lsb_cdb_value   = val;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(out_alu_valid), 32'd0);
    check("rst_full", 32'(out_dec_full), 32'd0);
    check("rst_rs1", out_alu_rs1, 32'd0);
    check("rst_pc", out_alu_pc, 32'd0);

    // 1: both operands ready, issue two edges after dispatch
    disp(OP_ADD, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 1'b1, 32'd0, 32'h100, 4'd3);
    tick();
    idle();
    check("t1_valid_e1", 32'(out_alu_valid), 32'd0);
    tick();
    check("t1_valid_e2", 32'(out_alu_valid), 32'd1);
    check("t1_op", 32'(out_alu_op), 32'(OP_ADD));
    check("t1_rs1", out_alu_rs1, 32'd5);
    check("t1_rs2", out_alu_rs2, 32'd7);
    check("t1_pc", out_alu_pc, 32'h100);
    check("t1_rob", 32'(out_alu_reorder), 32'd3);
    tick();
    check("t1_valid_e3", 32'(out_alu_valid), 32'd0);
    check("t1_rs1_hold", out_alu_rs1, 32'd5);

    // 2: wakeup from ALU CDB two cycles after dispatch
    disp(OP_ADDI, 32'd0, 4'd4, 1'b0, 32'd0, 4'd0, 1'b1, 32'd1, 32'h104, 4'd5);
    tick();
    idle();
    tick();
    check("t2_wait", 32'(out_alu_valid), 32'd0);
    alu_cdb(4'd4, 32'h10);
    tick();
    idle();
    check("t2_wake_edge", 32'(out_alu_valid), 32'd0);
    tick();
    check("t2_valid", 32'(out_alu_valid), 32'd1);
    check("t2_rs1", out_alu_rs1, 32'h10);
    check("t2_imm", out_alu_imm, 32'd1);
    check("t2_rob", 32'(out_alu_reorder), 32'd5);
    tick();

    // 3: dispatch-cycle bypass from LSB CDB
    disp(OP_ADD, 32'd0, 4'd6, 1'b0, 32'd2, 4'd0, 1'b1, 32'd0, 32'h108, 4'd7);
    lsb_cdb(4'd6, 32'hABCD);
    tick();
    idle();
    check("t3_disp_edge", 32'(out_alu_valid), 32'd0);
    tick();
    check("t3_valid", 32'(out_alu_valid), 32'd1);
    check("t3_rs1", out_alu_rs1, 32'hABCD);
    check("t3_rob", 32'(out_alu_reorder), 32'd7);
    tick();
    check("t3_idle", 32'(out_alu_valid), 32'd0);

    // 4: fill all entries; entry i waits on tag 8+i, reorder i
    for (int i = 0; i < 8; i++) begin
      check("t4_not_full", 32'(out_dec_full), 32'd0);
      disp(OP_SUB, 32'd0, 4'(8 + i), 1'b0, 32'd0, 4'd0, 1'b1, 32'd0, 32'(32'h200 + 4 * i), 4'(i));
      tick();
    end
    idle();
    check("t4_full", 32'(out_dec_full), 32'd1);
    check("t4_no_issue", 32'(out_alu_valid), 32'd0);
    alu_cdb(4'd13, 32'h55);
    tick();
    idle();
    check("t4_full_wake", 32'(out_dec_full), 32'd1);
    tick();
    check("t4_valid", 32'(out_alu_valid), 32'd1);
    check("t4_rob", 32'(out_alu_reorder), 32'd5);
    check("t4_rs1", out_alu_rs1, 32'h55);
    check("t4_full_clear", 32'(out_dec_full), 32'd0);
    disp(OP_OR, 32'h99, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd0, 32'h300, 4'd9);
    tick();
    idle();
    check("t4_refull", 32'(out_dec_full), 32'd1);
    check("t4_gap", 32'(out_alu_valid), 32'd0);
    tick();
    check("t4_reuse_valid", 32'(out_alu_valid), 32'd1);
    check("t4_reuse_rob", 32'(out_alu_reorder), 32'd9);
    check("t4_reuse_rs1", out_alu_rs1, 32'h99);
    check("t4_reuse_free", 32'(out_dec_full), 32'd0);

    // 5: entries 2 and 6 ready together, lower index first
    alu_cdb(4'd10, 32'h222);
    lsb_cdb(4'd14, 32'h666);
    tick();
    idle();
    check("t5_wake_edge", 32'(out_alu_valid), 32'd0);
    tick();
    check("t5_first_valid", 32'(out_alu_valid), 32'd1);
    check("t5_first_rob", 32'(out_alu_reorder), 32'd2);
    check("t5_first_rs1", out_alu_rs1, 32'h222);
    tick();
    check("t5_second_valid", 32'(out_alu_valid), 32'd1);
    check("t5_second_rob", 32'(out_alu_reorder), 32'd6);
    check("t5_second_rs1", out_alu_rs1, 32'h666);
    tick();
    check("t5_drained", 32'(out_alu_valid), 32'd0);

    // 6: flush with a ready entry and a concurrent dispatch
    alu_cdb(4'd8, 32'h88);
    tick();
    idle();
    disp(OP_ADD, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd0, 32'h400, 4'd11);
    in_rob_flush = 1'b1;
    tick();
    idle();
    in_rob_flush = 1'b0;
    check("t6_valid", 32'(out_alu_valid), 32'd0);
    check("t6_full", 32'(out_dec_full), 32'd0);
    tick();
    check("t6_stale1", 32'(out_alu_valid), 32'd0);
    tick();
    check("t6_stale2", 32'(out_alu_valid), 32'd0);

    // 7: rdy low holds outputs and ignores dispatch
    disp(OP_XOR, 32'h12, 4'd0, 1'b1, 32'd3, 4'd0, 1'b1, 32'd0, 32'h500, 4'd12);
    tick();
    idle();
    tick();
    check("t7_valid", 32'(out_alu_valid), 32'd1);
    check("t7_rob", 32'(out_alu_reorder), 32'd12);
    rdy = 1'b0;
    disp(OP_XOR, 32'h13, 4'd0, 1'b1, 32'd3, 4'd0, 1'b1, 32'd0, 32'h504, 4'd13);
    tick();
    check("t7_hold_valid", 32'(out_alu_valid), 32'd1);
    check("t7_hold_rob", 32'(out_alu_reorder), 32'd12);
    idle();
    rdy = 1'b1;
    tick();
    check("t7_ignored", 32'(out_alu_valid), 32'd0);
    tick();
    check("t7_ignored2", 32'(out_alu_valid), 32'd0);
    check("t7_rob_kept", 32'(out_alu_reorder), 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
